// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: core request/response and word-memory bus of the load/store unit.
// With LSU_FAULT_ADDR_EN defined the bus also carries rsp_fault_addr.
interface lsu_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;
`ifdef LSU_FAULT_ADDR_EN
    logic [31:0] rsp_fault_addr;
`endif

    // Core and memory side: issues requests, returns read data.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
`ifdef LSU_FAULT_ADDR_EN
        input  rsp_fault_addr,
`endif
        input  mem_address, mem_write_data, mem_write_enable
    );

    // LSU side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
`ifdef LSU_FAULT_ADDR_EN
        output rsp_fault_addr,
`endif
        output mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/lsu_rmw.sv
// lsu_rmw: RV32I load/store unit with sub-word read-modify-write in front of a word memory.
// Optional LSU_FAULT_ADDR_EN records the byte address of the last faulting access.
module lsu_rmw #(
    parameter int WORDS = 64
) (
    input logic      clk,
    input logic      rst,
    lsu_rmw_if.slave io_bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] RMW_READ = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_f3;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_hs;
    logic        w_bad_f3;
    logic        w_misalign;
    logic        w_range;
    logic        w_fault;
    logic [31:0] w_rd_sh;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_mask;
    logic [31:0] w_lane;
    logic [31:0] w_merged;
    logic        w_mem_busy;

    assign w_hs       = io_bus.req_valid && r_state == IDLE;
    assign w_bad_f3   = io_bus.req_we ? io_bus.req_funct3 > 3'd2
                                      : io_bus.req_funct3[1:0] == 2'b11 || io_bus.req_funct3 == 3'b110;
    assign w_misalign = (io_bus.req_funct3[1:0] == 2'b01 && io_bus.req_addr[0]) ||
                        (io_bus.req_funct3[1:0] == 2'b10 && io_bus.req_addr[1:0] != 2'b00);
    assign w_range    = io_bus.req_addr[31:2] >= 30'(WORDS);
    assign w_fault    = w_bad_f3 || w_misalign || w_range;

    // Load lane selection and sign/zero extension; funct3[2] marks the unsigned forms.
    assign w_rd_sh = io_bus.mem_read_data >> {r_addr[1:0], 3'b000};
    assign w_half  = r_addr[1] ? io_bus.mem_read_data[31:16] : io_bus.mem_read_data[15:0];
    assign w_load  = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_rd_sh[7]}}, w_rd_sh[7:0]}
                   : r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_half[15]}}, w_half}
                   : io_bus.mem_read_data;

    // Store merge: r_word still holds rs2 during RMW_READ; replicate it and keep only the target lanes.
    assign w_mask   = r_f3[0] ? 32'h0000_FFFF << {r_addr[1], 4'b0000}
                              : 32'h0000_00FF << {r_addr[1:0], 3'b000};
    assign w_lane   = r_f3[0] ? {2{r_word[15:0]}} : {4{r_word[7:0]}};
    assign w_merged = (io_bus.mem_read_data & ~w_mask) | (w_lane & w_mask);

    assign w_mem_busy              = r_state == LOAD || r_state == RMW_READ || r_state == WRITE;
    assign io_bus.req_ready        = r_state == IDLE;
    assign io_bus.rsp_valid        = r_state == RESP;
    assign io_bus.rsp_rdata        = r_rdata;
    assign io_bus.rsp_fault        = r_fault;
    assign io_bus.mem_address      = w_mem_busy ? {2'b00, r_addr[31:2]} : 32'h0;
    assign io_bus.mem_write_enable = r_state == WRITE;
    assign io_bus.mem_write_data   = r_state == WRITE ? r_word : 32'h0;

    // Request sequencing; response registers change only on entry to RESP so they hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_f3    <= 3'd0;
            r_word  <= 32'h0;
            r_rdata <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_hs) begin
                    r_addr <= io_bus.req_addr;
                    r_f3   <= io_bus.req_funct3;
                    r_word <= io_bus.req_wdata;
                    if (w_fault) begin
                        r_state <= RESP;
                        r_fault <= 1'b1;
                        r_rdata <= 32'h0;
                    end else begin
                        r_state <= !io_bus.req_we ? LOAD : io_bus.req_funct3 == 3'b010 ? WRITE : RMW_READ;
                    end
                end
                LOAD: begin
                    r_rdata <= w_load;
                    r_fault <= 1'b0;
                    r_state <= RESP;
                end
                RMW_READ: begin
                    r_word  <= w_merged;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_rdata <= 32'h0;
                    r_fault <= 1'b0;
                    r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LSU_FAULT_ADDR_EN
    logic [31:0] r_fault_addr;
    assign io_bus.rsp_fault_addr = r_fault_addr;

    // Capture the byte address of each rejected request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fault_addr <= 32'h0;
        else if (w_hs && w_fault) r_fault_addr <= io_bus.req_addr;
    end
`endif
endmodule
